// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared FSM encoding and chunk/lane arithmetic for the KNN training-data path
package knn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRESENT,
    ST_WAIT,
    ST_FINISH
  } state_t;

  function automatic int num_chunks(input int total, input int max_e);
    return (total + max_e - 1) / max_e;
  endfunction

  // Only the final chunk of a sample can come up short.
  function automatic int chunk_len(input int c, input int total, input int max_e);
    int rem;
    rem = total - c * max_e;
    return (rem < max_e) ? rem : max_e;
  endfunction

  function automatic int addr_base(input int s, input int c, input int sample_size, input int max_e);
    return s * sample_size + c * max_e;
  endfunction

  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/knn_chunk_loader.sv
// rtl/knn_chunk_loader.sv - reads one chunk from 1-cycle-latency memory and packs it into lanes
module knn_chunk_loader
  import knn_pkg::*;
#(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int W            = 16,
  parameter int MAX_ELEMENTS = 4,
  parameter int ADDR_W       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               go,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic [$clog2(MAX_ELEMENTS+1)-1:0]  len,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [W-1:0]                       mem_rd_data,
  output logic [W*M*N-1:0]                   data,
  output logic                               load_done
);

  localparam int MN    = M * N;
  localparam int LEN_W = $clog2(MAX_ELEMENTS + 1);

  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  cap_left;
  logic [LEN_W-1:0]  lane;
  logic              cap_valid;
  logic [W-1:0]      lanes [MAX_ELEMENTS];

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign load_done = cap_valid && (cap_left == LEN_W'(1));

  // cap_valid is the read strobe delayed by the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      issue_left <= '0;
      cap_left   <= '0;
      lane       <= '0;
      cap_valid  <= 1'b0;
      for (int k = 0; k < MAX_ELEMENTS; k++) lanes[k] <= '0;
    end else begin
      cap_valid <= rd_en_q;
      if (go) begin
        rd_en_q    <= 1'b1;
        addr_q     <= base_addr;
        issue_left <= len - LEN_W'(1);
        cap_left   <= len;
        lane       <= '0;
        for (int k = 0; k < MAX_ELEMENTS; k++) lanes[k] <= '0;
      end else begin
        if (rd_en_q) begin
          if (issue_left == '0) begin
            rd_en_q <= 1'b0;
          end else begin
            addr_q     <= addr_q + ADDR_W'(1);
            issue_left <= issue_left - LEN_W'(1);
          end
        end
        if (cap_valid) begin
          for (int k = 0; k < MAX_ELEMENTS; k++) begin
            if (lane == LEN_W'(k)) lanes[k] <= mem_rd_data;
          end
          lane     <= lane + LEN_W'(1);
          cap_left <= cap_left - LEN_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < MN; k++) begin : g_lane
    if (k < MAX_ELEMENTS) begin : g_live
      assign data[lane_lsb(k, W) +: W] = lanes[k];
    end else begin : g_zero
      assign data[lane_lsb(k, W) +: W] = '0;
    end
  end

endmodule

// File: rtl/knn_training_feeder.sv
// rtl/knn_training_feeder.sv - walks stored training samples and hands chunks to the distance calculator
module knn_training_feeder
  import knn_pkg::*;
#(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int W            = 16,
  parameter int MAX_ELEMENTS = 4,
  parameter int TYPE_W       = 2,
  parameter int NUM_SAMPLES  = 8,
  parameter int ADDR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                data_request,
  input  logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [W-1:0]        mem_rd_data,
  output logic                type_rd_en,
  output logic [ADDR_W-1:0]   type_addr,
  input  logic [TYPE_W-1:0]   type_rd_data,
  output logic [W*M*N-1:0]    training_data,
  output logic [TYPE_W-1:0]   training_data_type,
  output logic                ready,
  output logic                busy,
  output logic                all_done,
  output logic                err
);

  localparam int MN     = M * N;
  localparam int CHUNKS = num_chunks(MN, MAX_ELEMENTS);
  localparam int LEN_W  = $clog2(MAX_ELEMENTS + 1);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(CHUNKS - 1);
  localparam logic [ADDR_W-1:0] LAST_S = ADDR_W'(NUM_SAMPLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] s;
  logic [ADDR_W-1:0] c;
  logic              type_pending;
  logic              go;
  logic              load_done;
  logic [ADDR_W-1:0] go_s;
  logic [ADDR_W-1:0] go_c;
  logic [ADDR_W-1:0] go_addr;
  logic [LEN_W-1:0]  go_len;

  // go fires on the same edge that enters LOAD so the first read lands in LOAD's first cycle.
  always_comb begin
    go   = 1'b0;
    go_s = s;
    go_c = c;
    if (state == ST_IDLE && start) begin
      go   = 1'b1;
      go_s = '0;
      go_c = '0;
    end else if (state == ST_WAIT && done) begin
      if (s != LAST_S) begin
        go   = 1'b1;
        go_s = s + ADDR_W'(1);
        go_c = '0;
      end
    end else if (state == ST_WAIT && data_request && c != LAST_C) begin
      go   = 1'b1;
      go_c = c + ADDR_W'(1);
    end
    go_addr = ADDR_W'(addr_base(int'(go_s), int'(go_c), MN, MAX_ELEMENTS));
    go_len  = LEN_W'(chunk_len(int'(go_c), MN, MAX_ELEMENTS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      s                  <= '0;
      c                  <= '0;
      type_rd_en         <= 1'b0;
      type_addr          <= '0;
      type_pending       <= 1'b0;
      training_data_type <= '0;
      ready              <= 1'b0;
      busy               <= 1'b0;
      all_done           <= 1'b0;
      err                <= 1'b0;
    end else begin
      ready        <= 1'b0;
      all_done     <= 1'b0;
      type_rd_en   <= 1'b0;
      type_pending <= type_rd_en;
      if (type_pending) training_data_type <= type_rd_data;
      if (go) begin
        state <= ST_LOAD;
        s     <= go_s;
        c     <= go_c;
        if (go_c == '0) begin
          type_rd_en <= 1'b1;
          type_addr  <= go_s;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            err  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_done) begin
            state <= ST_PRESENT;
            ready <= 1'b1;
          end
          if (done || data_request) err <= 1'b1;
        end
        ST_PRESENT: begin
          state <= ST_WAIT;
          if (done || data_request) err <= 1'b1;
        end
        ST_WAIT: begin
          if (done) begin
            if (data_request) err <= 1'b1;
            if (s == LAST_S) begin
              state    <= ST_FINISH;
              s        <= '0;
              c        <= '0;
              all_done <= 1'b1;
              busy     <= 1'b0;
            end
          end else if (data_request && c == LAST_C) begin
            err <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          if (done || data_request) err <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  knn_chunk_loader #(
    .M            (M),
    .N            (N),
    .W            (W),
    .MAX_ELEMENTS (MAX_ELEMENTS),
    .ADDR_W       (ADDR_W)
  ) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .base_addr   (go_addr),
    .len         (go_len),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .data        (training_data),
    .load_done   (load_done)
  );

endmodule

// File: tb/tb_knn_training_feeder.sv
// tb/tb_knn_training_feeder.sv - self-checking bench for knn_training_feeder
module tb_knn_training_feeder;

  localparam int M      = 4;
  localparam int N      = 4;
  localparam int W      = 16;
  localparam int MAXE   = 5;
  localparam int TYPE_W = 2;
  localparam int NS     = 3;
  localparam int ADDR_W = 8;
  localparam int MN     = M * N;
  localparam int CH     = (MN + MAXE - 1) / MAXE;
  localparam int BUS    = W * M * N;
  localparam int WIN    = MAXE + 6;

  typedef enum {OP_START, OP_REQ, OP_DONE, OP_BOTH} op_t;
  typedef struct {
    op_t op;
    int  rdy;
    int  err;
    int  busy;
  } vec_t;

  logic              clk = 1'b0;
  bit                clk_run = 1'b1;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              data_request = 1'b0;
  logic              done = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_rd_data = '0;
  logic              type_rd_en;
  logic [ADDR_W-1:0] type_addr;
  logic [TYPE_W-1:0] type_rd_data = '0;
  logic [BUS-1:0]    training_data;
  logic [TYPE_W-1:0] training_data_type;
  logic              ready;
  logic              busy;
  logic              all_done;
  logic              err;

  logic [W-1:0]      mem [256];
  logic [TYPE_W-1:0] lbl [256];

  int n_vec = 0;
  int n_bad = 0;
  bit ready_d = 1'b0;

  bit m_busy = 1'b0;
  bit m_err  = 1'b0;
  int m_s    = 0;
  int m_c    = 0;

  vec_t tbl [14];

  knn_training_feeder #(
    .M(M), .N(N), .W(W), .MAX_ELEMENTS(MAXE), .TYPE_W(TYPE_W),
    .NUM_SAMPLES(NS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_request(data_request), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .type_rd_en(type_rd_en), .type_addr(type_addr), .type_rd_data(type_rd_data),
    .training_data(training_data), .training_data_type(training_data_type),
    .ready(ready), .busy(busy), .all_done(all_done), .err(err)
  );

  always #5 if (clk_run) clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (type_rd_en) type_rd_data <= lbl[type_addr];
  end

  always @(negedge clk) begin
    if (ready) begin
      n_vec++;
      if (ready_d) begin
        n_bad++;
        $display("FAIL ready_width: got 2+ cycles high, required 1");
      end
    end
    ready_d <= ready;
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int exp_len(input int c);
    int rem;
    rem = MN - c * MAXE;
    return (rem < MAXE) ? rem : MAXE;
  endfunction

  function automatic logic [BUS-1:0] exp_bus(input int s, input int c);
    logic [BUS-1:0] b;
    b = '0;
    for (int k = 0; k < MAXE; k++) begin
      if (c * MAXE + k < MN) b = b | (BUS'(mem[8'(s * MN + c * MAXE + k)]) << (k * W));
    end
    return b;
  endfunction

  task automatic model_step(input op_t op, output bit load, output bit fin);
    load = 1'b0;
    fin  = 1'b0;
    if (!m_busy) begin
      if (op == OP_START) begin
        m_busy = 1'b1; m_s = 0; m_c = 0; m_err = 1'b0; load = 1'b1;
      end
    end else if (op == OP_DONE || op == OP_BOTH) begin
      if (op == OP_BOTH) m_err = 1'b1;
      if (m_s == NS - 1) begin
        m_busy = 1'b0; fin = 1'b1;
      end else begin
        m_s++; m_c = 0; load = 1'b1;
      end
    end else if (op == OP_REQ) begin
      if (m_c == CH - 1) m_err = 1'b1;
      else begin
        m_c++; load = 1'b1;
      end
    end
  endtask

  // Called on a negedge; returns on a negedge once the DUT has settled.
  task automatic apply(input op_t op, input bit use_tbl, input int t_rdy, input int t_err, input int t_busy);
    bit p_load, p_fin;
    int rdy_at, n_rd, n_ad, n_rdy, got_type;
    logic [BUS-1:0] got_bus;
    model_step(op, p_load, p_fin);
    start        = (op == OP_START);
    data_request = (op == OP_REQ || op == OP_BOTH);
    done         = (op == OP_DONE || op == OP_BOTH);
    @(negedge clk);
    start = 1'b0; data_request = 1'b0; done = 1'b0;
    rdy_at = -1; n_rd = 0; n_ad = 0; n_rdy = 0; got_type = 0; got_bus = '0;
    for (int i = 1; i <= WIN; i++) begin
      if (i > 1) @(negedge clk);
      if (mem_rd_en) n_rd++;
      if (all_done) n_ad++;
      if (ready) begin
        n_rdy++;
        if (rdy_at < 0) begin
          rdy_at   = i;
          got_bus  = training_data;
          got_type = int'(training_data_type);
        end
      end
    end
    check_int("ready_pulses", n_rdy, p_load ? 1 : 0);
    check_int("mem_reads", n_rd, p_load ? exp_len(m_c) : 0);
    if (p_load) begin
      check_int("ready_latency", rdy_at, exp_len(m_c) + 2);
      check_bus("chunk", got_bus, exp_bus(m_s, m_c));
      check_int("label", got_type, int'(lbl[8'(m_s)]));
    end
    check_int("all_done_pulses", n_ad, p_fin ? 1 : 0);
    check_int("err", int'(err), m_err ? 1 : 0);
    check_int("busy", int'(busy), m_busy ? 1 : 0);
    if (use_tbl) begin
      check_int("tbl_ready", n_rdy, t_rdy);
      check_int("tbl_err", int'(err), t_err);
      check_int("tbl_busy", int'(busy), t_busy);
    end
  endtask

  task automatic drain_to_idle();
    for (int g = 0; g < NS + 1 && m_busy; g++) apply(OP_DONE, 1'b0, 0, 0, 0);
  endtask

  initial begin
    bit seen;
    for (int a = 0; a < 256; a++) begin
      mem[8'(a)] = W'($urandom);
      lbl[8'(a)] = TYPE_W'($urandom);
    end
    tbl[0]  = '{OP_REQ,   0, 0, 0};
    tbl[1]  = '{OP_DONE,  0, 0, 0};
    tbl[2]  = '{OP_START, 1, 0, 1};
    tbl[3]  = '{OP_REQ,   1, 0, 1};
    tbl[4]  = '{OP_REQ,   1, 0, 1};
    tbl[5]  = '{OP_REQ,   1, 0, 1};
    tbl[6]  = '{OP_REQ,   0, 1, 1};
    tbl[7]  = '{OP_START, 0, 1, 1};
    tbl[8]  = '{OP_DONE,  1, 1, 1};
    tbl[9]  = '{OP_BOTH,  1, 1, 1};
    tbl[10] = '{OP_REQ,   1, 1, 1};
    tbl[11] = '{OP_DONE,  0, 1, 0};
    tbl[12] = '{OP_DONE,  0, 1, 0};
    tbl[13] = '{OP_START, 1, 0, 1};

    repeat (3) @(negedge clk);
    check_int("reset_ctrl", int'({mem_rd_en, type_rd_en, ready, busy, all_done, err}), 0);
    check_int("reset_addr", int'({mem_addr, type_addr, training_data_type}), 0);
    check_bus("reset_bus", training_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 14; v++) apply(tbl[v].op, 1'b1, tbl[v].rdy, tbl[v].err, tbl[v].busy);

    for (int r = 0; r < 60; r++) begin
      int pick;
      op_t op;
      pick = $urandom_range(0, 9);
      if (pick < 5) op = OP_REQ;
      else if (pick < 8) op = OP_DONE;
      else if (pick < 9) op = OP_BOTH;
      else op = OP_START;
      apply(op, 1'b0, 0, 0, 0);
    end

    // A request arriving mid-LOAD is flagged and discarded; the chunk still completes.
    drain_to_idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_request = 1'b1;
    @(negedge clk);
    data_request = 1'b0;
    m_busy = 1'b1; m_s = 0; m_c = 0; m_err = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (ready) begin
        seen = 1'b1;
        check_bus("load_err_chunk", training_data, exp_bus(0, 0));
      end
      @(negedge clk);
    end
    check_int("load_err_ready_seen", int'(seen), 1);
    check_int("load_err_flag", int'(err), 1);
    @(negedge clk);
    apply(OP_REQ, 1'b0, 0, 0, 0);

    // Asynchronous reset while the clock is parked mid-LOAD.
    drain_to_idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_int("midload_rd_en", int'(mem_rd_en), 1);
    check_int("midload_busy", int'(busy), 1);
    clk_run = 1'b0;
    #17;
    rst_n = 1'b0;
    #1;
    check_int("async_reset_ctrl", int'({mem_rd_en, type_rd_en, ready, busy, all_done, err}), 0);
    check_int("async_reset_addr", int'({mem_addr, type_addr, training_data_type}), 0);
    check_bus("async_reset_bus", training_data, '0);
    #5;
    rst_n = 1'b1;
    m_busy = 1'b0; m_s = 0; m_c = 0; m_err = 1'b0;
    #5;
    clk_run = 1'b1;
    @(negedge clk);
    apply(OP_START, 1'b1, 1, 0, 1);
    apply(OP_REQ, 1'b0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/knn_training_feeder.md
Name: knn_training_feeder

Overview:
- Supplier side of the training-data handshake used by distance_calculator.
- Walks NUM_SAMPLES stored training samples. For each sample it fetches M*N elements from a 1-cycle-latency sample memory, MAX_ELEMENTS at a time, and presents each chunk on a packed bus with a single-cycle ready pulse.
- Advances to the next chunk on data_request and to the next sample on done.
- Sits between the training sample memory and the distance calculator; a top-level KNN controller starts it.

Parameters:
- M, 4, sample rows
- N, 4, sample columns
- W, 16, element width (bits)
- MAX_ELEMENTS, 4, elements per chunk; 1 <= MAX_ELEMENTS <= M*N
- TYPE_W, 2, class label width
- NUM_SAMPLES, 8, number of stored training samples (>= 1)
- ADDR_W, 8, memory address width; must hold NUM_SAMPLES*M*N-1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  pulse; begin a pass over all samples
- data_request  in  1  pulse from calculator; next chunk of current sample
- done  in  1  pulse from calculator; current sample finished
- mem_rd_en  out  1  element read strobe
- mem_addr  out  ADDR_W  element address
- mem_rd_data  in  W  element data, valid the cycle after mem_rd_en
- type_rd_en  out  1  label read strobe
- type_addr  out  ADDR_W  sample index
- type_rd_data  in  TYPE_W  label, valid the cycle after type_rd_en
- training_data  out  W*M*N  packed chunk; lane k = bits [(k+1)*W-1 -: W]
- training_data_type  out  TYPE_W  label of current sample
- ready  out  1  single-cycle pulse: chunk valid
- busy  out  1  high from start accepted until pass finished
- all_done  out  1  single-cycle pulse after last sample's done
- err  out  1  sticky protocol-error flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0; state IDLE; sample index s=0; chunk index c=0.
- Reset mid-operation aborts the pass immediately; no all_done is issued.
- Memory mapping:
  - element e of sample s is at address s*M*N+e
  - chunk c covers e = c*MAX_ELEMENTS .. min((c+1)*MAX_ELEMENTS, M*N)-1
  - CHUNKS = ceil(M*N/MAX_ELEMENTS)
  - E = number of elements in chunk c; the last chunk may be partial
- Lane packing: element c*MAX_ELEMENTS+k goes in lane k. Lanes >= E and all lanes >= MAX_ELEMENTS are driven 0. The bus is cleared at the start of each load.
- States: IDLE, LOAD, PRESENT, WAIT, FINISH.
- IDLE:
  - start -> LOAD with s=0, c=0, busy=1.
  - data_request or done arriving in IDLE are ignored and do not set err.
- LOAD (entered at cycle t):
  - mem_rd_en=1 for cycles t..t+E-1, with consecutive addresses.
  - Lane k is captured at the edge ending cycle t+k+1.
  - When c=0, type_rd_en=1 in cycle t with type_addr=s; the label is captured into training_data_type at the end of t+1.
  - After the last capture -> PRESENT.
- PRESENT: ready=1 for exactly one cycle (cycle t+E+1), then -> WAIT. Chunk and label stay stable until the next LOAD begins.
- WAIT:
  - done -> s+1, c=0.
    - If s was NUM_SAMPLES-1 -> FINISH.
    - Otherwise -> LOAD.
  - data_request with c < CHUNKS-1 -> c+1 -> LOAD.
  - data_request with c = CHUNKS-1: set err, stay in WAIT.
  - done and data_request in the same cycle: done wins, err is set.
- FINISH: all_done=1 for one cycle, busy=0 -> IDLE.
- start while busy: ignored, err unaffected.
- data_request or done during LOAD/PRESENT/FINISH: set err, pulse discarded.
- err clears only on reset or on an accepted start.
- Latency: the first ready after start comes E+2 cycles after the start edge. ready is never held high, so the calculator cannot re-trigger on a stale chunk.

Decomposition:
- Package knn_pkg: state encoding, CHUNKS and CHUNK_LEN(c) constant functions, address-base helper, and the lane index/width conventions shared with distance_calculator.
- One natural sub-module: knn_chunk_loader. It issues the E reads, aligns the 1-cycle read latency, packs lanes, and returns load_done. The top-level FSM owns s, c, and the handshake.

Test Plan:
- Basic chunking: M=N=4, MAX_ELEMENTS=4, NUM_SAMPLES=2, memory[a]=a, labels {1,2}; start pulse -> first ready 6 cycles later with lanes {0,1,2,3}, type=1. Three data_request pulses yield {4..7},{8..11},{12..15}. done -> sample 1 lanes {16..19}, type=2.
- Partial last chunk: MAX_ELEMENTS=5, M=N=4 -> chunks of 5,5,5,1. Last chunk lane0=15, lanes 1..4=0, ready 3 cycles after its LOAD begins.
- End of pass: done after the final sample -> exactly one all_done pulse, busy falls the same cycle, no further mem_rd_en.
- Protocol errors: data_request after the last chunk sets err and does not change state; simultaneous done+data_request advances the sample and sets err; a new start clears err.
- Back-to-back with a distance_calculator model: full pass distances match a software model; ready is never high for more than 1 cycle.
- Async reset asserted mid-LOAD with clk stopped -> all outputs 0 immediately; after release, start restarts at address 0.
